// File: rtl/pipelined_cla_adder_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder:
//   GRP_W  : width of one lookahead group (one pipeline stage per group)
//   mode_e : operation select carried with each operand bundle
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GRP_W = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,    // a + b + cin
        MODE_SUB = 1'b1     // a - b, formed as a + ~b + 1
    } mode_e;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder_if
// Valid/ready bundle interface of the pipelined adder.
//   Input side : in_valid, in_ready, a, b, cin, mode
//   Output side: out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : the producer/consumer around the adder (drives operands, out_ready)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    mode_e            mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_cla_adder_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead slice.
//   i_a, i_b : 4-bit operand group
//   i_ci     : carry into bit 0
//   o_s      : 4-bit sum
//   o_co     : carry out of bit 3
//   o_p, o_g : group propagate / group generate
//   o_c3     : carry into bit 3 (used for signed overflow on the top group)
// Every carry is a flat sum-of-products of g/p terms; no carry feeds another.
// ---------------------------------------------------------------------------
module cla4_slice
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] i_a,
    input  logic [GRP_W-1:0] i_b,
    input  logic             i_ci,
    output logic [GRP_W-1:0] o_s,
    output logic             o_co,
    output logic             o_p,
    output logic             o_g,
    output logic             o_c3
);

    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_g;
    logic [GRP_W-1:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_g  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p  = &w_p;
    assign o_co = o_g | (o_p & i_ci);
    assign o_s  = w_p ^ w_c;
    assign o_c3 = w_c[3];

endmodule

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder/subtractor split into NGRP = WIDTH/4 pipeline stages, one
// 4-bit lookahead group per stage; the group carry is registered between
// stages. Valid/ready flow control stalls the whole pipeline at once.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (valid bits and outputs only)
//   bus   : slave side of pipelined_cla_adder_if (operands in, result out)
// Latency NGRP cycles, one result per cycle.
// ---------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);

    localparam int NGRP = WIDTH / GRP_W;

    logic w_advance;

    // The pipeline only moves when the output slot is empty or being drained.
    assign w_advance    = !g_stg[NGRP-1].r_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_stg
            localparam int LO = gi * GRP_W;     // LSB of this stage's group
            localparam int WB = WIDTH - LO;     // b bits still unconsumed on entry

            logic             w_valid_in;
            logic [WIDTH-1:0] w_sa_in;
            logic [WIDTH-1:0] w_sa_next;
            logic [WB-1:0]    w_b_in;
            logic             w_ci;
            logic [GRP_W-1:0] w_s;
            logic             w_co;
            logic             w_p;
            logic             w_g;
            logic             w_c3;

            // r_sa: finished sum groups below this stage, raw a groups above.
            logic             r_valid;
            logic             r_carry;
            logic [WIDTH-1:0] r_sa;

            if (gi == 0) begin : g_head
                // b is conditioned once here; the inverted value then travels
                // with the bundle, so later mode changes cannot affect it.
                assign w_valid_in = bus.in_valid;
                assign w_sa_in    = bus.a;
                assign w_b_in     = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                assign w_ci       = (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
            end else begin : g_body
                assign w_valid_in = g_stg[gi-1].r_valid;
                assign w_sa_in    = g_stg[gi-1].r_sa;
                assign w_b_in     = g_stg[gi-1].g_skew.r_b;
                assign w_ci       = g_stg[gi-1].r_carry;
            end

            cla4_slice u_slice (
                .i_a  (w_sa_in[LO +: GRP_W]),
                .i_b  (w_b_in[GRP_W-1:0]),
                .i_ci (w_ci),
                .o_s  (w_s),
                .o_co (w_co),
                .o_p  (w_p),
                .o_g  (w_g),
                .o_c3 (w_c3)
            );

            always_comb begin
                w_sa_next              = w_sa_in;
                w_sa_next[LO +: GRP_W] = w_s;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_valid_in;
                end
            end

            if (gi == NGRP-1) begin : g_tail
                // Last stage doubles as the output register, so it is reset.
                logic r_ovf;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sa    <= '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                    end else if (w_advance) begin
                        r_sa    <= w_sa_next;
                        r_carry <= w_co;
                        r_ovf   <= w_c3 ^ w_co;
                    end
                end
            end else begin : g_skew
                // Only the b groups above this stage are kept.
                logic [WB-GRP_W-1:0] r_b;

                always_ff @(posedge clk) begin
                    if (w_advance) begin
                        r_sa    <= w_sa_next;
                        r_carry <= w_co;
                        r_b     <= w_b_in[WB-1:GRP_W];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = g_stg[NGRP-1].r_valid;
    assign bus.sum       = g_stg[NGRP-1].r_sa;
    assign bus.cout      = g_stg[NGRP-1].r_carry;
    assign bus.ovf       = g_stg[NGRP-1].g_tail.r_ovf;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; a multiple of 4 and at least 8.
REQ-002 SHALL have derived localparam NGRP = WIDTH/4, the number of 4-bit lookahead groups and pipeline stages.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand bundle valid.
REQ-006 in_ready  out  1  block accepts a bundle this cycle.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry in; ignored in SUB mode.
REQ-010 mode  in  1  0 = ADD (a+b+cin), 1 = SUB (a-b, computed as a+~b+1).
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  out  1  carry out of the MSB (SUB: 1 = no borrow).
REQ-015 ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-017 advance = !out_valid || out_ready; the whole pipeline SHALL shift only when advance = 1, and in_ready SHALL equal advance (combinational).
REQ-018 Stage k (0..NGRP-1) SHALL add group bits [4k+3:4k] with a 4-bit lookahead slice, using the carry registered by stage k-1; stage 0 SHALL use cin (ADD) or 1 (SUB).
REQ-019 Operand groups not yet consumed SHALL be carried forward in skew registers; completed sum groups SHALL be carried forward in de-skew registers, so each stage sees the correct operands.
REQ-020 Each stage SHALL hold a valid bit; a bubble (no transfer in while advancing) SHALL propagate as valid = 0.
REQ-021 Latency SHALL be exactly NGRP cycles from transfer in to out_valid when out_ready is held high; throughput SHALL be one result per cycle.
REQ-022 While out_ready = 0 and out_valid = 1, sum/cout/ovf/out_valid and all stage registers SHALL hold, and no input SHALL be accepted.
REQ-023 Simultaneous transfer in and transfer out SHALL both complete in the same cycle with no loss or duplication.
REQ-024 mode SHALL be captured with the operands and travel with them; changing mode between bundles SHALL NOT affect in-flight bundles.
REQ-025 Results SHALL leave in acceptance order; occupancy SHALL never exceed NGRP.

Reset
REQ-026 On rst_n = 0: all valid bits, out_valid, sum, cout and ovf SHALL go to 0 immediately.
REQ-027 Reset mid-operation SHALL discard all in-flight bundles; in_ready SHALL be 1 in the first cycle after release.
REQ-028 Data/skew registers need no reset; reset affects valid bits and outputs only.

Structure
REQ-029 Shared package cla_pkg SHALL hold GRP_W = 4 and the mode enum (MODE_ADD = 0, MODE_SUB = 1).
REQ-030 One sub-module, cla4_slice, SHALL be instantiated NGRP times; it is purely combinational (a[3:0], b[3:0], ci -> s[3:0], co, group P, group G).
REQ-031 cla4_slice SHALL compute all internal carries by lookahead from generate/propagate terms (no ripple), and SHALL also expose the carry into bit 3 for ovf on the top slice.

Verification (WIDTH = 16, latency 4)
REQ-032 ADD 0x00FF + 0x0001, cin = 0, out_ready = 1 -> 4 cycles later: sum = 0x0100, cout = 0, ovf = 0.
REQ-033 ADD 0xFFFF + 0x0000, cin = 1 -> sum = 0x0000, cout = 1, ovf = 0 (carry crosses all 4 stages); ADD 0x7FFF + 0x0001 -> sum = 0x8000, ovf = 1.
REQ-034 SUB 0x0005 - 0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0; SUB 0x8000 - 0x0001 -> sum = 0x7FFF, ovf = 1.
REQ-035 Back-to-back stream of 8 bundles, out_ready low for cycles 5-7 -> outputs hold during the stall, in_ready = 0 during the stall, all 8 results arrive in order and correct.
REQ-036 Assert rst_n = 0 with 3 bundles in flight -> out_valid drops at once, no stale result appears after release, and the first new bundle emerges 4 cycles after acceptance.
REQ-037 Random ADD/SUB with mixed mode and random out_ready, 10k bundles, checked against a reference model -> zero mismatches; also run WIDTH = 8 and WIDTH = 32.
